// File: rtl/fas_peak_analyzer_pkg.sv
// Shared constants and types for the FFT peak analyzer: bin format, power word, scan FSM states.
package fas_peak_analyzer_pkg;
  localparam int N_PTS = 16;
  localparam int DW    = 16;
  localparam int IDX_W = 4;

  // Packed so a 32-bit bin word maps directly: [31:16]=re, [15:0]=im.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef logic [2*DW-1:0] mag_t;

  typedef enum logic {IDLE, SCAN} fft_st_e;
endpackage

// File: rtl/fas_peak_analyzer_if.sv
// Frame input and result output bundle of the peak analyzer.
interface fas_peak_analyzer_if;
  import fas_peak_analyzer_pkg::*;

  logic                       fft_valid;
  logic [N_PTS-1:0][31:0]     fft_d;
  logic                       done;
  logic [IDX_W-1:0]           freq;
  logic                       busy;
  logic                       ovf;

  modport master (output fft_valid, fft_d, input done, freq, busy, ovf);
  modport slave  (input fft_valid, fft_d, output done, freq, busy, ovf);
endinterface

// File: rtl/fas_peak_analyzer_mag_sq.sv
// Power of one complex bin: re^2 + im^2. Max is 2*2^30, so 32 unsigned bits never overflow.
module fas_mag_sq
  import fas_peak_analyzer_pkg::*;
(
  input  cplx_t c_i,
  output mag_t  mag_o
);
  logic signed [2*DW-1:0] re_x, im_x, rr, ii;

  assign re_x  = {{DW{c_i.re[DW-1]}}, c_i.re};
  assign im_x  = {{DW{c_i.im[DW-1]}}, c_i.im};
  assign rr    = re_x * re_x;
  assign ii    = im_x * im_x;
  assign mag_o = mag_t'(rr) + mag_t'(ii);
endmodule

// File: rtl/fas_peak_analyzer.sv
// Ping-pong frame capture and one-bin-per-cycle argmax scan over per-bin power.
module fas_peak_analyzer
  import fas_peak_analyzer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fas_peak_analyzer_if.slave bus
);
  cplx_t            bank_q [2][N_PTS];
  logic [1:0]       vld_q, vld_d;
  fft_st_e          st_q;
  logic             sel_q;
  logic [IDX_W-1:0] idx_q, arg_q, arg_d, freq_q;
  mag_t             max_q, max_d, mag;
  logic             done_q, ovf_q;
  logic             act, act_bank, last, better, wr_en, wr_bank, ovf_d;
  cplx_t            cur;

  // While idle, a valid bank is scanned starting on this very edge so latency stays fixed.
  always_comb begin
    act      = (st_q == SCAN) || (|vld_q);
    act_bank = (st_q == SCAN) ? sel_q : ~vld_q[0];
    cur      = bank_q[act_bank][idx_q];
    better   = (idx_q == '0) || (mag > max_q);
    arg_d    = better ? idx_q : arg_q;
    max_d    = better ? mag : max_q;
    last     = act && (idx_q == IDX_W'(N_PTS-1));
    wr_en    = bus.fft_valid && !(&vld_q);
    wr_bank  = vld_q[0];
    ovf_d    = bus.fft_valid && (&vld_q);
    vld_d    = vld_q;
    if (last)  vld_d[act_bank] = 1'b0;
    if (wr_en) vld_d[wr_bank]  = 1'b1;
  end

  fas_mag_sq u_mag (.c_i(cur), .mag_o(mag));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      sel_q  <= 1'b0;
      idx_q  <= '0;
      max_q  <= '0;
      arg_q  <= '0;
      vld_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      freq_q <= '0;
    end else begin
      vld_q  <= vld_d;
      done_q <= last;
      ovf_q  <= ovf_d;
      if (act) begin
        idx_q <= idx_q + 1'b1;
        max_q <= max_d;
        arg_q <= arg_d;
      end
      // The other bank only counts if it was already valid before this edge.
      if (last) begin
        freq_q <= arg_d;
        sel_q  <= ~act_bank;
        st_q   <= vld_q[~act_bank] ? SCAN : IDLE;
      end else if (act) begin
        sel_q <= act_bank;
        st_q  <= SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int k = 0; k < N_PTS; k++) bank_q[wr_bank][k] <= cplx_t'(bus.fft_d[k]);
    end
  end

  assign bus.done = done_q;
  assign bus.freq = freq_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (st_q == SCAN) || (|vld_q);
endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Randomized + directed bench for the peak analyzer against a frame-level timing model.
module tb_fas_peak_analyzer;
  import fas_peak_analyzer_pkg::*;

  typedef logic [N_PTS-1:0][31:0] frame_t;
  typedef struct {int cap; int st; int en; int arg;} fr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fas_peak_analyzer_if bus();
  fas_peak_analyzer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, failures = 0, tm = 0;
  fr_t q[$];
  logic e_done = 0, e_busy = 0, e_ovf = 0;
  int e_freq = 0, occ, last_en;
  int done_tm[$], done_fq[$], ovf_tm[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", n, tm, act, exp);
    end
  endtask

  function automatic int argmax(frame_t f);
    longint best = -1, m, r, i;
    int a = 0;
    for (int k = 0; k < N_PTS; k++) begin
      r = longint'($signed(f[k][31:16]));
      i = longint'($signed(f[k][15:0]));
      m = r * r + i * i;
      if (m > best) begin best = m; a = k; end
    end
    return a;
  endfunction

  // Model: each accepted frame is scanned for 16 edges, right after the previous one or after capture.
  always @(posedge clk) begin
    tm++;
    if (rst) begin
      q.delete();
      e_done = 0; e_busy = 0; e_ovf = 0; e_freq = 0;
    end else begin
      e_ovf = 0;
      if (bus.fft_valid) begin
        occ = 0; last_en = tm;
        foreach (q[k]) begin
          if (q[k].cap < tm && q[k].en >= tm) occ++;
          if (q[k].en > last_en) last_en = q[k].en;
        end
        if (occ < 2) q.push_back('{tm, last_en + 1, last_en + 16, argmax(bus.fft_d)});
        else e_ovf = 1;
      end
      e_done = 0; e_busy = 0;
      foreach (q[k]) begin
        if (q[k].en == tm) begin e_done = 1; e_freq = q[k].arg; end
        if (q[k].cap <= tm && tm < q[k].en) e_busy = 1;
      end
      while (q.size() > 0 && q[0].en < tm) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("done", 32'(bus.done), 32'(e_done));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("ovf",  32'(bus.ovf),  32'(e_ovf));
    chk("freq", 32'(bus.freq), 32'(e_freq));
    if (bus.done === 1'b1) begin done_tm.push_back(tm); done_fq.push_back(int'(bus.freq)); end
    if (bus.ovf === 1'b1) ovf_tm.push_back(tm);
  end

  function automatic frame_t peak(int p);
    frame_t f;
    for (int k = 0; k < N_PTS; k++) f[k] = 32'h0010_0008;
    f[p] = 32'h0100_0000;
    return f;
  endfunction

  function automatic frame_t rnd_frame(int mode);
    frame_t f;
    logic [15:0] lv [4];
    lv[0] = 16'h0000; lv[1] = 16'h0100; lv[2] = 16'hFF00; lv[3] = 16'h0200;
    for (int k = 0; k < N_PTS; k++) begin
      if (mode == 0) f[k] = $urandom;
      else if (mode == 1) f[k] = {lv[$urandom_range(3)], lv[$urandom_range(3)]};
      else f[k] = '0;
    end
    return f;
  endfunction

  task automatic send(input frame_t f, output int cap);
    bus.fft_d = f; bus.fft_valid = 1'b1;
    @(negedge clk);
    cap = tm;
    bus.fft_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_log();
    done_tm.delete(); done_fq.delete(); ovf_tm.delete();
  endtask

  initial begin
    frame_t f;
    int c0, c1, c2, cc, prob;
    bus.fft_valid = 1'b0; bus.fft_d = '0;
    idle(3);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_freq", 32'(bus.freq), 0);

    // 1: single frame, peak at bin 5; done 16 edges after capture
    clr_log();
    f = '0; f[5] = 32'h0400_0300;
    send(f, c0); idle(20);
    chk("t1_ndone", done_tm.size(), 1);
    if (done_tm.size() >= 1) begin
      chk("t1_lat", done_tm[0] - c0, 16);
      chk("t1_freq", done_fq[0], 5);
    end
    chk("t1_busy", 32'(bus.busy), 0);

    // 2: tie between bins 3 and 9
    clr_log();
    f = '0; f[3] = 32'h0200_0000; f[9] = 32'h0200_0000; f[0] = 32'h0100_0100;
    send(f, c0); idle(20);
    chk("t2_ndone", done_tm.size(), 1);
    if (done_tm.size() >= 1) chk("t2_freq", done_fq[0], 3);

    // 3: most-negative fields give the largest power
    clr_log();
    f = '0; f[12] = 32'h8000_8000; f[1] = 32'h7FFF_7FFF;
    send(f, c0); idle(20);
    chk("t3_ndone", done_tm.size(), 1);
    if (done_tm.size() >= 1) chk("t3_freq", done_fq[0], 12);

    // 4: back-to-back every 16 cycles
    clr_log();
    send(peak(2), c0); idle(15);
    send(peak(7), c1); idle(15);
    send(peak(0), c2); idle(20);
    chk("t4_ndone", done_tm.size(), 3);
    chk("t4_novf", ovf_tm.size(), 0);
    if (done_tm.size() >= 3) begin
      chk("t4_lat0", done_tm[0] - c0, 16);
      chk("t4_lat1", done_tm[1] - c1, 16);
      chk("t4_lat2", done_tm[2] - c2, 16);
      chk("t4_f0", done_fq[0], 2);
      chk("t4_f1", done_fq[1], 7);
      chk("t4_f2", done_fq[2], 0);
    end

    // 5: three frames on consecutive edges, third dropped
    clr_log();
    send(peak(4), c0); send(peak(6), c1); send(peak(8), c2); idle(40);
    chk("t5_ndone", done_tm.size(), 2);
    chk("t5_novf", ovf_tm.size(), 1);
    if (ovf_tm.size() >= 1) chk("t5_ovf_edge", ovf_tm[0] - c0, 2);
    if (done_tm.size() >= 2) begin
      chk("t5_f0", done_fq[0], 4);
      chk("t5_f1", done_fq[1], 6);
      chk("t5_t1", done_tm[1] - c0, 32);
    end

    // 6: reset mid-scan with a frame pending
    clr_log();
    send(peak(9), c0); send(peak(11), c1); idle(6);
    rst = 1'b1; idle(1); rst = 1'b0; idle(25);
    chk("t6_ndone", done_tm.size(), 0);
    chk("t6_freq", 32'(bus.freq), 0);
    chk("t6_busy", 32'(bus.busy), 0);

    // Random traffic: varying frame density, data styles, rare resets
    for (int blk = 0; blk < 8; blk++) begin
      prob = (blk % 4 == 0) ? 2 : (blk % 4 == 1) ? 8 : (blk % 4 == 2) ? 16 : 30;
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(399) == 0) begin
          rst = 1'b1; idle(1); rst = 1'b0;
        end else if ($urandom_range(prob - 1) == 0) begin
          send(rnd_frame($urandom_range(9) < 6 ? 0 : ($urandom_range(3) == 0 ? 2 : 1)), cc);
        end else begin
          idle(1);
        end
      end
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
